// File: rtl/mhd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mhd_pkg
// Purpose : Shared definitions for the Hamming-distance statistics path.
//           Holds the default distance width (tied to the 64-bit miter, whose
//           per-vector distance spans 0..64), the accumulator state encoding
//           and the result record layout shared with the downstream reporter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mhd_pkg;

    // A 64-bit miter produces distances 0..64, which needs 7 bits.
    localparam int c_mhd_dist_w = 7;
    // Default sample-counter width; run length up to 2^16-1 vectors.
    localparam int c_mhd_cnt_w  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mhd_state_t;

    // Result record at the default widths.  The sum is wide enough that a
    // full-length run of maximum distances cannot overflow.
    typedef struct packed {
        logic [c_mhd_cnt_w+c_mhd_dist_w-1:0] sum;
        logic [c_mhd_dist_w-1:0]             max;
        logic [c_mhd_cnt_w-1:0]              err_cnt;
        logic [c_mhd_cnt_w-1:0]              over_cnt;
    } mhd_result_t;

endpackage : mhd_pkg
`default_nettype wire

// File: rtl/mhd_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : mhd_accumulator
// Purpose : Streaming statistics over a run of per-vector Hamming distances.
//           A run of num_samples distances is accumulated into sum, maximum,
//           non-zero count and over-threshold count; the record is then
//           offered once through a valid/ready handshake.
// Ports   : clk, rst           - clock, synchronous active-high reset
//           start, num_samples, thresh
//                              - run request and its latched parameters
//           in_valid/in_ready/in_dist
//                              - distance stream (one sample per cycle)
//           busy               - any state other than idle
//           res_valid/res_ready
//                              - result handshake
//           res_sum, res_max, res_err_cnt, res_over_cnt
//                              - result record, straight from accumulators
// Revision: 1.0 - initial release
// ============================================================================
module mhd_accumulator
    import mhd_pkg::*;
#(
    parameter  int DIST_W = c_mhd_dist_w,
    parameter  int CNT_W  = c_mhd_cnt_w,
    localparam int SUM_W  = CNT_W + DIST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic [DIST_W-1:0] thresh,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIST_W-1:0] in_dist,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SUM_W-1:0]  res_sum,
    output logic [DIST_W-1:0] res_max,
    output logic [CNT_W-1:0]  res_err_cnt,
    output logic [CNT_W-1:0]  res_over_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    mhd_state_t         r_state;
    mhd_state_t         w_state_nxt;

    logic               w_in_ready;
    logic               w_res_valid;
    logic               w_busy;
    logic               w_start_acc;
    logic               w_beat;

    logic [CNT_W-1:0]   r_num_samples;
    logic [DIST_W-1:0]  r_thresh;
    // Number of samples accepted so far in this run.
    logic [CNT_W-1:0]   r_count;
    logic [SUM_W-1:0]   r_sum;
    logic [DIST_W-1:0]  r_max;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [CNT_W-1:0]   r_over_cnt;

    assign w_start_acc = start && (r_state == ST_IDLE);
    assign w_beat      = in_valid && w_in_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and decoded outputs.  in_ready depends only on the state,
    // so res_ready never reaches in_ready combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_res_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    // An empty run has nothing to accumulate.
                    w_state_nxt = (num_samples == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                w_in_ready = 1'b1;
                // The beat carrying the final sample closes the run.
                if (in_valid && (r_count == r_num_samples - c_cnt_one)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_res_valid = 1'b1;
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Statistics datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_samples <= '0;
            r_thresh      <= '0;
            r_count       <= '0;
            r_sum         <= '0;
            r_max         <= '0;
            r_err_cnt     <= '0;
            r_over_cnt    <= '0;
        end else if (w_start_acc) begin
            r_num_samples <= num_samples;
            r_thresh      <= thresh;
            r_count       <= '0;
            r_sum         <= '0;
            r_max         <= '0;
            r_err_cnt     <= '0;
            r_over_cnt    <= '0;
        end else if (w_beat) begin
            r_count <= r_count + c_cnt_one;
            r_sum   <= r_sum + {{CNT_W{1'b0}}, in_dist};
            if (in_dist > r_max) begin
                r_max <= in_dist;
            end
            if (in_dist != '0) begin
                r_err_cnt <= r_err_cnt + c_cnt_one;
            end
            if (in_dist > r_thresh) begin
                r_over_cnt <= r_over_cnt + c_cnt_one;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign res_valid    = w_res_valid;
    assign busy         = w_busy;
    assign res_sum      = r_sum;
    assign res_max      = r_max;
    assign res_err_cnt  = r_err_cnt;
    assign res_over_cnt = r_over_cnt;

endmodule : mhd_accumulator
`default_nettype wire

// File: tb/tb_mhd_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_mhd_accumulator
// Purpose : Self-checking bench for mhd_accumulator.  Expected records come
//           from a plain-arithmetic model of each run and are queued; a
//           monitor pops and compares on every result handshake.  A second
//           instance with 4-bit counters exercises a maximum-length run.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mhd_accumulator;

    localparam int DIST_W = 7;
    localparam int CNT_W  = 16;
    localparam int SUM_W  = CNT_W + DIST_W;
    localparam int CNT4_W = 4;
    localparam int SUM4_W = CNT4_W + DIST_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  num_samples;
    logic [DIST_W-1:0] thresh;
    logic              in_valid;
    logic              in_ready;
    logic [DIST_W-1:0] in_dist;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [SUM_W-1:0]  res_sum;
    logic [DIST_W-1:0] res_max;
    logic [CNT_W-1:0]  res_err_cnt;
    logic [CNT_W-1:0]  res_over_cnt;

    logic               s_start;
    logic [CNT4_W-1:0]  s_num;
    logic [DIST_W-1:0]  s_thr;
    logic               s_valid;
    logic               s_ready;
    logic [DIST_W-1:0]  s_dist;
    logic               s_busy;
    logic               s_res_valid;
    logic               s_res_ready;
    logic [SUM4_W-1:0]  s_sum;
    logic [DIST_W-1:0]  s_max;
    logic [CNT4_W-1:0]  s_err;
    logic [CNT4_W-1:0]  s_over;

    mhd_accumulator #(.DIST_W(DIST_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_samples  (num_samples),
        .thresh       (thresh),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dist      (in_dist),
        .busy         (busy),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_sum      (res_sum),
        .res_max      (res_max),
        .res_err_cnt  (res_err_cnt),
        .res_over_cnt (res_over_cnt)
    );

    mhd_accumulator #(.DIST_W(DIST_W), .CNT_W(CNT4_W)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .start        (s_start),
        .num_samples  (s_num),
        .thresh       (s_thr),
        .in_valid     (s_valid),
        .in_ready     (s_ready),
        .in_dist      (s_dist),
        .busy         (s_busy),
        .res_valid    (s_res_valid),
        .res_ready    (s_res_ready),
        .res_sum      (s_sum),
        .res_max      (s_max),
        .res_err_cnt  (s_err),
        .res_over_cnt (s_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint sum;
        int     max;
        int     err;
        int     over;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks;
    int   n_errs;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: statistics of a run computed directly from the list.
    function automatic rec_t model(input int d[$], input int thr);
        rec_t r;
        r.sum  = 0;
        r.max  = 0;
        r.err  = 0;
        r.over = 0;
        foreach (d[i]) begin
            r.sum += d[i];
            if (d[i] > r.max) r.max = d[i];
            if (d[i] != 0)    r.err++;
            if (d[i] > thr)   r.over++;
        end
        return r;
    endfunction

    task automatic idle_check(input string tag);
        chk({tag, " busy"},      busy,         0);
        chk({tag, " in_ready"},  in_ready,     0);
        chk({tag, " res_valid"}, res_valid,    0);
        chk({tag, " sum"},       res_sum,      0);
        chk({tag, " max"},       res_max,      0);
        chk({tag, " err"},       res_err_cnt,  0);
        chk({tag, " over"},      res_over_cnt, 0);
    endtask

    task automatic abort_run();
        start     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    // bubble_pct < 0 selects a strict 1,0,1,0 in_valid pattern.
    // poke pulses start (num_samples=99) during RUN, DONE and the handshake.
    task automatic run_case(input string tag, input int thr, input int d[$],
                            input int bubble_pct, input int ready_delay,
                            input bit poke);
        rec_t e;
        int   n;
        int   idx;
        int   cyc;
        int   dv;
        n = d.size();
        e = model(d, thr);
        exp_q.push_back(e);

        @(posedge clk); #1;
        start       = 1'b1;
        num_samples = n[CNT_W-1:0];
        thresh      = thr[DIST_W-1:0];
        @(posedge clk); #1;
        start       = 1'b0;
        num_samples = 16'd99;

        idx = 0;
        cyc = 0;
        while (idx < n) begin
            if (cyc > 4 * n + 20) begin
                chk({tag, " feed timeout"}, idx, n);
                abort_run();
                return;
            end
            if (bubble_pct < 0) in_valid = (cyc % 2 == 0);
            else                in_valid = ($urandom_range(99) >= bubble_pct);
            dv      = d[idx];
            in_dist = dv[DIST_W-1:0];
            start   = poke && (cyc == 1);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;

        // Cycle after the last beat: result up, further samples refused.
        in_valid = 1'b1;
        in_dist  = 7'd64;
        @(negedge clk);
        chk({tag, " extra beat refused"}, in_ready,  0);
        chk({tag, " res_valid latency"},  res_valid, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;

        for (int k = 0; k < ready_delay; k++) begin
            start = poke && (k == 0);
            @(negedge clk);
            chk({tag, " held valid"}, res_valid, 1);
            chk({tag, " held sum"},   res_sum,   e.sum);
            chk({tag, " held max"},   res_max,   e.max);
            @(posedge clk); #1;
        end

        res_ready = 1'b1;
        start     = poke;
        cyc       = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!res_valid && cyc < 20);
        if (!res_valid) begin
            chk({tag, " result timeout"}, res_valid, 1);
            abort_run();
            return;
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        chk({tag, " idle after handshake"}, busy,      0);
        chk({tag, " valid dropped"},        res_valid, 0);
    endtask

    task automatic run4(input int thr, input int exp_over);
        @(posedge clk); #1;
        s_start = 1'b1;
        s_num   = 4'd15;
        s_thr   = thr[DIST_W-1:0];
        @(posedge clk); #1;
        s_start = 1'b0;
        s_valid = 1'b1;
        s_dist  = 7'd64;
        repeat (15) @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("max-len res_valid", s_res_valid, 1);
        chk("max-len sum",       s_sum,       960);
        chk("max-len max",       s_max,       64);
        chk("max-len err",       s_err,       15);
        chk("max-len over",      s_over,      exp_over);
        s_res_ready = 1'b1;
        @(posedge clk); #1;
        s_res_ready = 1'b0;
        @(negedge clk);
        chk("max-len idle", s_busy, 0);
    endtask

    initial begin
        int qa[$];
        int n;
        int thr;
        n_checks    = 0;
        n_errs      = 0;
        rst         = 1'b1;
        start       = 1'b0;
        num_samples = '0;
        thresh      = '0;
        in_valid    = 1'b0;
        in_dist     = '0;
        res_ready   = 1'b0;
        s_start     = 1'b0;
        s_num       = '0;
        s_thr       = '0;
        s_valid     = 1'b0;
        s_dist      = '0;
        s_res_ready = 1'b0;

        fork
            begin : monitor
                rec_t me;
                forever begin
                    @(negedge clk);
                    if (res_valid && res_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected result", 1, 0);
                        end else begin
                            me = exp_q.pop_front();
                            chk("result sum",  res_sum,      me.sum);
                            chk("result max",  res_max,      me.max);
                            chk("result err",  res_err_cnt,  me.err);
                            chk("result over", res_over_cnt, me.over);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        idle_check("reset");

        // Reset in the middle of a run discards partial data.
        @(posedge clk); #1;
        start       = 1'b1;
        num_samples = 16'd10;
        thresh      = 7'd5;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_dist  = 7'd20;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrun partial sum", res_sum, 60);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        idle_check("midrun reset");

        qa = {0, 3, 2, 64};
        run_case("basic", 2, qa, 0, 0, 1'b0);

        qa = {5, 9, 1};
        run_case("bubble", 4, qa, -1, 5, 1'b0);

        qa.delete();
        run_case("zero", 10, qa, 0, 1, 1'b0);

        qa = {4, 4, 8, 1, 0, 6};
        run_case("ignstart", 3, qa, 0, 2, 1'b1);

        // Values above 64 are accumulated as given.
        qa = {127, 65, 0, 100};
        run_case("wide", 64, qa, 20, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            qa.delete();
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(9) == 0)      qa.push_back(0);
                else if ($urandom_range(9) == 0) qa.push_back($urandom_range(65, 127));
                else                             qa.push_back($urandom_range(0, 64));
            end
            thr = $urandom_range(0, 70);
            run_case("rand", thr, qa, $urandom_range(0, 50), $urandom_range(0, 3), 1'b0);
        end

        run4(63, 15);
        run4(64, 0);

        chk("scoreboard drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule : tb_mhd_accumulator
`default_nettype wire
